// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and constants for the ttt event scheduler.
package ttt_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_e;
    localparam logic [1:0] TOKEN_START = 2'b01;
    localparam logic [1:0] TOKEN_STOP = 2'b10;
    function automatic int pid_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tt_um_jleugeri_ttt_event_scheduler_if.sv
// tt_um_jleugeri_ttt_event_scheduler_if: scheduler-to-network dispatch handshake.
interface tt_um_jleugeri_ttt_event_scheduler_if #(parameter int PID_W = 4) ();
    logic valid;
    logic [PID_W-1:0] source_id;
    logic [1:0] token_startstop;
    logic done;
    modport master (output valid, source_id, token_startstop, input done);
    modport slave (input valid, source_id, token_startstop, output done);
endinterface

// File: rtl/tt_um_jleugeri_ttt_rr_arbiter.sv
// tt_um_jleugeri_ttt_rr_arbiter: combinational round-robin pick starting after last_grant.
module tt_um_jleugeri_ttt_rr_arbiter #(
    parameter int N = 10,
    parameter int PID_W = 4
) (
    input  logic [N-1:0] req,
    input  logic [PID_W-1:0] last_grant,
    output logic [PID_W-1:0] grant,
    output logic any
);
    logic [2*N-1:0] dbl;
    logic [N-1:0] rot;
    logic [PID_W:0] off, sum;
    always_comb begin
        // rotate so bit 0 is the processor right after last_grant
        dbl = {req, req} >> ({1'b0, last_grant} + 1'b1);
        rot = dbl[N-1:0];
        off = '0;
        for (int i = N - 1; i >= 0; i--) off = rot[i] ? (PID_W+1)'(i) : off;
        sum = {1'b0, last_grant} + (PID_W+1)'(1) + off;
        grant = PID_W'(sum >= (PID_W+1)'(N) ? sum - (PID_W+1)'(N) : sum);
        any = |req;
    end
endmodule

// File: rtl/tt_um_jleugeri_ttt_event_scheduler.sv
// tt_um_jleugeri_ttt_event_scheduler: queues per-processor start/stop events and dispatches them round-robin to the network.
module tt_um_jleugeri_ttt_event_scheduler
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS = 10,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DROP_CNT_BITS = 8,
    localparam int PID_W = pid_w(NUM_PROCESSORS)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic [NUM_PROCESSORS-1:0] evt_start,
    input  logic [NUM_PROCESSORS-1:0] evt_stop,
    output logic busy,
    output logic [NUM_PROCESSORS-1:0] pending,
    output logic overflow,
    output logic timeout_err,
    output logic [DROP_CNT_BITS-1:0] drop_count,
    input  logic clear_status,
    tt_um_jleugeri_ttt_event_scheduler_if.master net
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DROP_MAX = (1 << DROP_CNT_BITS) - 1;
    sched_state_e state, state_nx;
    logic [NUM_PROCESSORS-1:0] pend_start, pend_stop, clr, drop_s, drop_p;
    logic [PID_W-1:0] last_grant, g;
    logic any, grant_now, tmo;
    logic [TW-1:0] timer;
    logic [DROP_CNT_BITS-1:0] drop_nx;
    int drop_sum;
    tt_um_jleugeri_ttt_rr_arbiter #(.N(NUM_PROCESSORS), .PID_W(PID_W)) u_arb (
        .req(pending), .last_grant(last_grant), .grant(g), .any(any)
    );
    assign pending = pend_start | pend_stop;
    assign busy = state != IDLE;
    // the granted processor's bits are being cleared, so a same-cycle event re-arms rather than drops
    assign drop_s = evt_start & pend_start & ~clr;
    assign drop_p = evt_stop & pend_stop & ~clr;
    always_comb begin
        grant_now = state == IDLE && run && any;
        tmo = state == WAIT && !net.done && timer == TW'(TIMEOUT_CYCLES - 1);
        state_nx = grant_now ? ISSUE : state == ISSUE ? WAIT : (state == WAIT && (net.done || tmo)) ? IDLE : state;
        clr = grant_now ? NUM_PROCESSORS'(1) << g : '0;
        drop_sum = int'(drop_count) + $countones(drop_s) + $countones(drop_p);
        drop_nx = drop_sum > DROP_MAX ? '1 : DROP_CNT_BITS'(drop_sum);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pend_start <= '0;
            pend_stop <= '0;
            last_grant <= PID_W'(NUM_PROCESSORS - 1);
            timer <= '0;
            net.valid <= 1'b0;
            net.source_id <= '0;
            net.token_startstop <= '0;
            overflow <= 1'b0;
            timeout_err <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_nx;
            pend_start <= (pend_start & ~clr) | evt_start;
            pend_stop <= (pend_stop & ~clr) | evt_stop;
            net.valid <= grant_now;
            if (grant_now) begin
                net.source_id <= g;
                net.token_startstop <= (pend_start[g] ? TOKEN_START : 2'b00) | (pend_stop[g] ? TOKEN_STOP : 2'b00);
                last_grant <= g;
            end
            timer <= state == WAIT ? timer + TW'(1) : '0;
            overflow <= clear_status ? 1'b0 : overflow | (|drop_s) | (|drop_p);
            timeout_err <= clear_status ? 1'b0 : timeout_err | tmo;
            drop_count <= clear_status ? '0 : drop_nx;
        end
    end
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_scheduler.sv
// tb_tt_um_jleugeri_ttt_event_scheduler: directed per-cycle vectors plus timeout and reset sequences.
module tb_tt_um_jleugeri_ttt_event_scheduler;
    typedef struct {
        logic rst_n, run, done, clr;
        logic [9:0] start, stop;
        logic valid;
        logic [3:0] src;
        logic [1:0] tok;
        logic busy;
        logic [9:0] pend;
        logic ovf;
        logic [7:0] drop;
    } vec_t;

    logic clk = 0, reset, run, clear_status, busy, overflow, timeout_err;
    logic [9:0] evt_start, evt_stop, pending;
    logic [7:0] drop_count;
    int checks = 0, errors = 0;
    vec_t vecs[$];

    tt_um_jleugeri_ttt_event_scheduler_if #(.PID_W(4)) net ();
    tt_um_jleugeri_ttt_event_scheduler dut (
        .clk(clk), .reset(reset), .run(run), .evt_start(evt_start), .evt_stop(evt_stop),
        .busy(busy), .pending(pending), .overflow(overflow), .timeout_err(timeout_err),
        .drop_count(drop_count), .clear_status(clear_status), .net(net)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic r, logic ru, logic d, logic c, logic [9:0] s, logic [9:0] p,
                               logic va, logic [3:0] sr, logic [1:0] tk, logic b, logic [9:0] pe,
                               logic o, logic [7:0] dr);
        vec_t x;
        x.rst_n = r; x.run = ru; x.done = d; x.clr = c; x.start = s; x.stop = p;
        x.valid = va; x.src = sr; x.tok = tk; x.busy = b; x.pend = pe; x.ovf = o; x.drop = dr;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic ru, input logic d, input logic [9:0] s, input logic [9:0] p);
        reset = r; run = ru; net.done = d; evt_start = s; evt_stop = p; clear_status = 0;
    endtask

    initial begin
        drive(0, 1, 0, 0, 0);
        clear_status = 0;
        // reset
        vecs.push_back(v(0,1,0,0,'h000,'h000, 0,0,0,0,'h000,0,0));
        vecs.push_back(v(0,1,0,0,'h000,'h000, 0,0,0,0,'h000,0,0));
        // single start event on processor 3
        vecs.push_back(v(1,1,0,0,'h008,'h000, 0,0,0,0,'h008,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,3,1,1,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,3,1,1,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,3,1,1,'h000,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,3,1,0,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,3,1,0,'h000,0,0));
        // round robin from a fresh pointer
        vecs.push_back(v(0,1,0,0,'h000,'h000, 0,0,0,0,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h221, 0,0,0,0,'h221,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,0,2,1,'h220,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,0,2,1,'h220,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,0,2,0,'h220,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,5,2,1,'h200,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,5,2,1,'h200,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,5,2,0,'h200,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,9,2,1,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,9,2,1,'h000,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,9,2,0,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h201, 0,9,2,0,'h201,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,0,2,1,'h200,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,0,2,1,'h200,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,0,2,0,'h200,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,9,2,1,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,9,2,1,'h000,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,9,2,0,'h000,0,0));
        // start and stop together
        vecs.push_back(v(1,1,0,0,'h004,'h004, 0,9,2,0,'h004,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,2,3,1,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,2,3,1,'h000,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,2,3,0,'h000,0,0));
        // overflow while busy with processor 7, then clear
        vecs.push_back(v(1,1,0,0,'h080,'h000, 0,2,3,0,'h080,0,0));
        vecs.push_back(v(1,1,0,0,'h010,'h000, 1,7,1,1,'h010,0,0));
        vecs.push_back(v(1,1,0,0,'h010,'h000, 0,7,1,1,'h010,1,1));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,7,1,0,'h010,1,1));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,4,1,1,'h000,1,1));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,4,1,1,'h000,1,1));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,4,1,0,'h000,1,1));
        vecs.push_back(v(1,1,0,1,'h000,'h000, 0,4,1,0,'h000,0,0));
        // event for the granted processor in its grant cycle re-arms without a drop
        vecs.push_back(v(1,1,0,0,'h002,'h000, 0,4,1,0,'h002,0,0));
        vecs.push_back(v(1,1,0,0,'h002,'h000, 1,1,1,1,'h002,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,1,1,1,'h002,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,1,1,0,'h002,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,1,1,1,'h000,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 0,1,1,1,'h000,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,1,1,0,'h000,0,0));
        // run=0 holds grants; done during ISSUE is ignored
        vecs.push_back(v(1,0,0,0,'h040,'h000, 0,1,1,0,'h040,0,0));
        vecs.push_back(v(1,0,0,0,'h000,'h000, 0,1,1,0,'h040,0,0));
        vecs.push_back(v(1,0,0,0,'h000,'h000, 0,1,1,0,'h040,0,0));
        vecs.push_back(v(1,1,0,0,'h000,'h000, 1,6,1,1,'h000,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,6,1,1,'h000,0,0));
        vecs.push_back(v(1,1,1,0,'h000,'h000, 0,6,1,0,'h000,0,0));

        #2;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].run, vecs[i].done, vecs[i].start, vecs[i].stop);
            clear_status = vecs[i].clr;
            tick();
            chk($sformatf("row%0d valid", i), 32'(net.valid), 32'(vecs[i].valid));
            chk($sformatf("row%0d src", i), 32'(net.source_id), 32'(vecs[i].src));
            chk($sformatf("row%0d tok", i), 32'(net.token_startstop), 32'(vecs[i].tok));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("row%0d pending", i), 32'(pending), 32'(vecs[i].pend));
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("row%0d drop_count", i), 32'(drop_count), 32'(vecs[i].drop));
            chk($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'(0));
        end

        // timeout: processor 8 never gets done; processor 3 queued meanwhile
        drive(1, 1, 0, 'h100, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        chk("tmo grant valid", 32'(net.valid), 1);
        chk("tmo grant src", 32'(net.source_id), 8);
        tick();
        chk("tmo in wait", 32'(busy), 1);
        drive(1, 1, 0, 'h008, 0); tick();
        drive(1, 1, 0, 0, 0);
        for (int k = 1; k < 63; k++) tick();
        chk("tmo before limit busy", 32'(busy), 1);
        chk("tmo before limit err", 32'(timeout_err), 0);
        tick();
        chk("tmo abort busy", 32'(busy), 0);
        chk("tmo abort err", 32'(timeout_err), 1);
        chk("tmo abort pending", 32'(pending), 'h008);
        tick();
        chk("tmo next valid", 32'(net.valid), 1);
        chk("tmo next src", 32'(net.source_id), 3);
        chk("tmo next tok", 32'(net.token_startstop), 1);
        tick();
        drive(1, 1, 1, 0, 0); tick();
        chk("tmo done idle", 32'(busy), 0);

        // reset mid-WAIT clears everything, including the sticky timeout
        drive(1, 1, 0, 'h020, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        chk("rst grant src", 32'(net.source_id), 5);
        tick();
        chk("rst in wait", 32'(busy), 1);
        drive(0, 1, 0, 0, 0); tick();
        chk("rst valid", 32'(net.valid), 0);
        chk("rst src", 32'(net.source_id), 0);
        chk("rst tok", 32'(net.token_startstop), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst pending", 32'(pending), 0);
        chk("rst timeout_err", 32'(timeout_err), 0);
        drive(1, 0, 0, 'h003, 0); tick();
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d valid", k), 32'(net.valid), 0);
            chk($sformatf("hold%0d busy", k), 32'(busy), 0);
            chk($sformatf("hold%0d pending", k), 32'(pending), 'h003);
            tick();
        end
        drive(1, 1, 0, 0, 0); tick();
        chk("post-rst valid", 32'(net.valid), 1);
        chk("post-rst src", 32'(net.source_id), 0);
        chk("post-rst pending", 32'(pending), 'h002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
